// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared constants for the PC fetch unit.
//   - pc_sel encodings (sequential / ALU target / JAL target / re-boot)
//   - FSM state encodings
//   - canonical NOP and the default reset PC
//   - align_word(): clears the byte-offset bits of a fetch target
package pc_fetch_unit_pkg;

  localparam logic [1:0] PC_SEL_SEQ  = 2'd0;
  localparam logic [1:0] PC_SEL_ALU  = 2'd1;
  localparam logic [1:0] PC_SEL_JAL  = 2'd2;
  localparam logic [1:0] PC_SEL_BOOT = 2'd3;

  localparam logic [1:0] ST_RESET    = 2'd0;
  localparam logic [1:0] ST_BOOT     = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  // Substituted downstream for any word flagged by kill_s1 (addi x0,x0,0).
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h4000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: control/fetch bundle between the pipeline and the
// fetch unit.
//   pc_sel[1:0], alu_target[31:0], jal_target[31:0], stall : to fetch unit
//   imem_addr[31:0], pc_s1[31:0], fetch_valid, kill_s1,
//   redirect_cnt[31:0]                                     : from fetch unit
// Modports: slave = the fetch unit, master = the pipeline/controller.
interface pc_fetch_unit_if;
  logic [1:0]  pc_sel;
  logic [31:0] alu_target;
  logic [31:0] jal_target;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] pc_s1;
  logic        fetch_valid;
  logic        kill_s1;
  logic [31:0] redirect_cnt;

  modport master (
    output pc_sel, alu_target, jal_target, stall,
    input  imem_addr, pc_s1, fetch_valid, kill_s1, redirect_cnt
  );

  modport slave (
    input  pc_sel, alu_target, jal_target, stall,
    output imem_addr, pc_s1, fetch_valid, kill_s1, redirect_cnt
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter generation for a synchronous-read IMEM.
// imem_addr is presented this cycle, the word comes back next cycle tagged
// with pc_s1 and either fetch_valid (real fetch) or kill_s1 (wrong path,
// replace with NOP).
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-high reset
//   bus (slave) - pc_sel / targets / stall in; imem_addr, pc_s1,
//                 fetch_valid, kill_s1, redirect_cnt out
// Parameter RESET_PC: first fetch address after reset or re-boot.
// Optional feature: define PC_FETCH_REDIRECT_CNT_EN to build a 32-bit
// counter of taken redirects; otherwise redirect_cnt is tied to 0.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  pc_fetch_unit_if.slave   bus
);

  logic [1:0]  r_state;
  logic [31:0] r_imem_addr;
  logic [31:0] r_pc_s1;
  logic        r_fetch_valid;
  logic        r_kill_s1;

  logic        w_reboot;
  logic        w_redirect;
  logic [31:0] w_target;

  assign w_reboot   = (bus.pc_sel == PC_SEL_BOOT);
  assign w_redirect = (bus.pc_sel == PC_SEL_ALU) || (bus.pc_sel == PC_SEL_JAL);
  assign w_target   = align_word((bus.pc_sel == PC_SEL_ALU) ? bus.alu_target
                                                             : bus.jal_target);

  // Priority: leaving RESET always goes to BOOT (no fetch can be valid
  // before boot), then re-boot, then redirect (beats stall), then stall
  // hold, then sequential advance. The word returned next cycle is always
  // the one at the current r_imem_addr, hence pc_s1 <= r_imem_addr on
  // every move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RESET;
      r_imem_addr   <= RESET_PC;
      r_pc_s1       <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_kill_s1     <= 1'b1;
    end else if (r_state == ST_RESET) begin
      r_state       <= ST_BOOT;
      r_imem_addr   <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_kill_s1     <= 1'b1;
    end else if (w_reboot) begin
      r_state       <= ST_BOOT;
      r_pc_s1       <= r_imem_addr;
      r_imem_addr   <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_kill_s1     <= 1'b1;
    end else if (w_redirect) begin
      r_state       <= ST_REDIRECT;
      r_pc_s1       <= r_imem_addr;
      r_imem_addr   <= w_target;
      r_fetch_valid <= 1'b0;
      r_kill_s1     <= 1'b1;
    end else if (!bus.stall) begin
      // BOOT, RUN and REDIRECT all resolve to RUN on a plain advance.
      r_state       <= ST_RUN;
      r_pc_s1       <= r_imem_addr;
      r_imem_addr   <= r_imem_addr + 32'd4;
      r_fetch_valid <= 1'b1;
      r_kill_s1     <= 1'b0;
    end
  end

  assign bus.imem_addr   = r_imem_addr;
  assign bus.pc_s1       = r_pc_s1;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.kill_s1     = r_kill_s1;

`ifdef PC_FETCH_REDIRECT_CNT_EN
  logic [31:0] r_redirect_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect_cnt <= '0;
    end else if (r_state != ST_RESET) begin
      if (w_reboot)        r_redirect_cnt <= '0;
      else if (w_redirect) r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  assign bus.redirect_cnt = r_redirect_cnt;
`else
  assign bus.redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: self-checking bench for pc_fetch_unit. A behavioural
// model tracks "which address is out to memory" and "is the word coming
// back good", and directed tasks plus a randomized run compare against it.
module tb_pc_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h4000_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pc_fetch_unit_if bus();

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the address in flight, the PC/goodness of the word
  // returned this cycle, whether we are still in reset, redirect tally.
  logic [31:0] m_addr;
  logic [31:0] m_pc;
  bit          m_good;
  bit          m_in_reset;
  logic [31:0] m_cnt;

  function automatic logic [31:0] cnt_exp();
`ifdef PC_FETCH_REDIRECT_CNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_addr     = RST_PC;
    m_pc       = RST_PC;
    m_good     = 1'b0;
    m_in_reset = 1'b1;
    m_cnt      = 32'd0;
  endtask

  // One clock edge: the model consumes the inputs seen at the edge, then
  // time moves 1 unit past the edge so outputs are settled for sampling.
  task automatic tick();
    logic [1:0]  sel;
    logic [31:0] tgt;
    @(posedge clk);
    sel = bus.pc_sel;
    if (m_in_reset) begin
      m_in_reset = 1'b0;
      m_addr     = RST_PC;
      m_good     = 1'b0;
    end else if (sel == 2'd3) begin
      m_pc   = m_addr;
      m_good = 1'b0;
      m_addr = RST_PC;
      m_cnt  = 32'd0;
    end else if (sel == 2'd1 || sel == 2'd2) begin
      tgt    = (sel == 2'd1) ? bus.alu_target : bus.jal_target;
      m_pc   = m_addr;
      m_good = 1'b0;
      m_addr = tgt & 32'hFFFF_FFFC;
      m_cnt  = m_cnt + 32'd1;
    end else if (!bus.stall) begin
      m_pc   = m_addr;
      m_good = 1'b1;
      m_addr = m_addr + 32'd4;
    end
    #1;
  endtask

  task automatic set_in(input logic [1:0] sel, input logic st,
                        input logic [31:0] alu, input logic [31:0] jal);
    bus.pc_sel     = sel;
    bus.stall      = st;
    bus.alu_target = alu;
    bus.jal_target = jal;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #3;
    n_checks++;
    if (bus.imem_addr !== RST_PC || bus.pc_s1 !== RST_PC ||
        bus.fetch_valid !== 1'b0 || bus.kill_s1 !== 1'b1 || bus.redirect_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values: got addr=%h pc=%h v=%b k=%b cnt=%h want %h %h 0 1 0",
               bus.imem_addr, bus.pc_s1, bus.fetch_valid, bus.kill_s1, bus.redirect_cnt,
               RST_PC, RST_PC);
    end
    // Reset held across edges with a redirect requested: nothing moves.
    set_in(2'd1, 1'b0, 32'h1234_5678, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (bus.imem_addr !== RST_PC || bus.fetch_valid !== 1'b0 || bus.kill_s1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_held: got addr=%h v=%b k=%b want %h 0 1",
               bus.imem_addr, bus.fetch_valid, bus.kill_s1, RST_PC);
    end
    set_in(2'd0, 1'b0, 32'h0, 32'h0);
    #2 rst = 1'b0;   // release between edges
  endtask

  task automatic test_boot();
    tick();  // RESET -> BOOT
    n_checks++;
    if (bus.imem_addr !== 32'h4000_0000 || bus.fetch_valid !== 1'b0 || bus.kill_s1 !== 1'b1) begin
      n_fail++;
      $display("FAIL boot_cycle: got addr=%h v=%b k=%b want 40000000 0 1",
               bus.imem_addr, bus.fetch_valid, bus.kill_s1);
    end
    tick();
    n_checks++;
    if (bus.imem_addr !== 32'h4000_0004 || bus.pc_s1 !== 32'h4000_0000 ||
        bus.fetch_valid !== 1'b1 || bus.kill_s1 !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_first_valid: got addr=%h pc=%h v=%b k=%b want 40000004 40000000 1 0",
               bus.imem_addr, bus.pc_s1, bus.fetch_valid, bus.kill_s1);
    end
    tick();
    n_checks++;
    if (bus.imem_addr !== 32'h4000_0008 || bus.pc_s1 !== 32'h4000_0004 || bus.fetch_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL boot_seq: got addr=%h pc=%h v=%b want 40000008 40000004 1",
               bus.imem_addr, bus.pc_s1, bus.fetch_valid);
    end
  endtask

  task automatic test_redirect();
    set_in(2'd1, 1'b0, 32'h4000_0103, 32'h0);
    tick();
    n_checks++;
    if (bus.imem_addr !== 32'h4000_0100 || bus.kill_s1 !== 1'b1 ||
        bus.fetch_valid !== 1'b0 || bus.pc_s1 !== 32'h4000_0008) begin
      n_fail++;
      $display("FAIL redirect_alu: got addr=%h pc=%h v=%b k=%b want 40000100 40000008 0 1",
               bus.imem_addr, bus.pc_s1, bus.fetch_valid, bus.kill_s1);
    end
    set_in(2'd0, 1'b0, 32'h0, 32'h0);
    tick();
    n_checks++;
    if (bus.imem_addr !== 32'h4000_0104 || bus.pc_s1 !== 32'h4000_0100 ||
        bus.fetch_valid !== 1'b1 || bus.kill_s1 !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_resume: got addr=%h pc=%h v=%b k=%b want 40000104 40000100 1 0",
               bus.imem_addr, bus.pc_s1, bus.fetch_valid, bus.kill_s1);
    end
  endtask

  task automatic test_back_to_back();
    set_in(2'd2, 1'b0, 32'h0, 32'h4000_2002);
    tick();
    n_checks++;
    if (bus.imem_addr !== 32'h4000_2000 || bus.kill_s1 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_jal: got addr=%h k=%b want 40002000 1", bus.imem_addr, bus.kill_s1);
    end
    set_in(2'd1, 1'b0, 32'h4000_3001, 32'h0);
    tick();
    n_checks++;
    if (bus.imem_addr !== 32'h4000_3000 || bus.kill_s1 !== 1'b1 ||
        bus.fetch_valid !== 1'b0 || bus.pc_s1 !== 32'h4000_2000) begin
      n_fail++;
      $display("FAIL b2b_alu: got addr=%h pc=%h v=%b k=%b want 40003000 40002000 0 1",
               bus.imem_addr, bus.pc_s1, bus.fetch_valid, bus.kill_s1);
    end
    set_in(2'd0, 1'b0, 32'h0, 32'h0);
    tick();
    n_checks++;
    if (bus.pc_s1 !== 32'h4000_3000 || bus.fetch_valid !== 1'b1 ||
        bus.kill_s1 !== 1'b0 || bus.imem_addr !== 32'h4000_3004) begin
      n_fail++;
      $display("FAIL b2b_resume: got addr=%h pc=%h v=%b k=%b want 40003004 40003000 1 0",
               bus.imem_addr, bus.pc_s1, bus.fetch_valid, bus.kill_s1);
    end
  endtask

  task automatic test_stall();
    set_in(2'd1, 1'b0, 32'h4000_000C, 32'h0);
    tick();
    set_in(2'd0, 1'b0, 32'h0, 32'h0);
    tick();  // now imem_addr = 4000_0010, returning 4000_000C
    set_in(2'd0, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.imem_addr !== 32'h4000_0010 || bus.pc_s1 !== 32'h4000_000C ||
          bus.fetch_valid !== 1'b1 || bus.kill_s1 !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got addr=%h pc=%h v=%b k=%b want 40000010 4000000c 1 0",
                 i, bus.imem_addr, bus.pc_s1, bus.fetch_valid, bus.kill_s1);
      end
    end
    set_in(2'd2, 1'b1, 32'h0, 32'h0000_0040);
    tick();
    n_checks++;
    if (bus.imem_addr !== 32'h0000_0040 || bus.kill_s1 !== 1'b1 || bus.pc_s1 !== 32'h4000_0010) begin
      n_fail++;
      $display("FAIL stall_redirect: got addr=%h pc=%h k=%b want 00000040 40000010 1",
               bus.imem_addr, bus.pc_s1, bus.kill_s1);
    end
    set_in(2'd0, 1'b0, 32'h0, 32'h0);
    tick();
    n_checks++;
    if (bus.pc_s1 !== 32'h0000_0040 || bus.fetch_valid !== 1'b1 || bus.imem_addr !== 32'h0000_0044) begin
      n_fail++;
      $display("FAIL stall_resume: got addr=%h pc=%h v=%b want 00000044 00000040 1",
               bus.imem_addr, bus.pc_s1, bus.fetch_valid);
    end
  endtask

  task automatic test_wrap();
    set_in(2'd1, 1'b0, 32'hFFFF_FFFE, 32'h0);
    tick();
    n_checks++;
    if (bus.imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_setup: got addr=%h want fffffffc", bus.imem_addr);
    end
    set_in(2'd0, 1'b0, 32'h0, 32'h0);
    tick();
    n_checks++;
    if (bus.imem_addr !== 32'h0000_0000 || bus.pc_s1 !== 32'hFFFF_FFFC || bus.fetch_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap: got addr=%h pc=%h v=%b want 00000000 fffffffc 1",
               bus.imem_addr, bus.pc_s1, bus.fetch_valid);
    end
  endtask

  task automatic test_reboot();
    for (int i = 0; i < 5; i++) begin
      set_in(2'(1 + (i % 2)), 1'b0, 32'h4000_1000 + 32'(i * 16), 32'h4000_2000 + 32'(i * 16));
      tick();
    end
    n_checks++;
    if (bus.redirect_cnt !== cnt_exp()) begin
      n_fail++;
      $display("FAIL cnt_after_redirects: got %h want %h", bus.redirect_cnt, cnt_exp());
    end
    set_in(2'd3, 1'b0, 32'h0, 32'h0);
    tick();
    n_checks++;
    if (bus.imem_addr !== RST_PC || bus.kill_s1 !== 1'b1 || bus.fetch_valid !== 1'b0 ||
        bus.redirect_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reboot: got addr=%h v=%b k=%b cnt=%h want %h 0 1 0",
               bus.imem_addr, bus.fetch_valid, bus.kill_s1, bus.redirect_cnt, RST_PC);
    end
    set_in(2'd0, 1'b0, 32'h0, 32'h0);
    tick();
    n_checks++;
    if (bus.pc_s1 !== RST_PC || bus.fetch_valid !== 1'b1 || bus.imem_addr !== RST_PC + 32'd4) begin
      n_fail++;
      $display("FAIL reboot_resume: got addr=%h pc=%h v=%b want %h %h 1",
               bus.imem_addr, bus.pc_s1, bus.fetch_valid, RST_PC + 32'd4, RST_PC);
    end
  endtask

  task automatic test_reset_mid_redirect();
    for (int i = 0; i < 5; i++) begin
      set_in(2'd1, 1'b0, 32'h4000_0500 + 32'(i * 8), 32'h0);
      tick();
    end
    n_checks++;
    if (bus.redirect_cnt !== cnt_exp()) begin
      n_fail++;
      $display("FAIL cnt_before_rst: got %h want %h", bus.redirect_cnt, cnt_exp());
    end
    #2 rst = 1'b1;   // between edges, still in REDIRECT with a target pending
    model_reset();
    #1;
    n_checks++;
    if (bus.imem_addr !== RST_PC || bus.pc_s1 !== RST_PC || bus.fetch_valid !== 1'b0 ||
        bus.kill_s1 !== 1'b1 || bus.redirect_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL async_rst: got addr=%h pc=%h v=%b k=%b cnt=%h want %h %h 0 1 0",
               bus.imem_addr, bus.pc_s1, bus.fetch_valid, bus.kill_s1, bus.redirect_cnt,
               RST_PC, RST_PC);
    end
    #1 rst = 1'b0;
    set_in(2'd0, 1'b0, 32'h0, 32'h0);
    tick();
    n_checks++;
    if (bus.fetch_valid !== 1'b0 || bus.imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL rst_then_boot: got addr=%h v=%b want %h 0", bus.imem_addr, bus.fetch_valid, RST_PC);
    end
    tick();
    n_checks++;
    if (bus.fetch_valid !== 1'b1 || bus.pc_s1 !== RST_PC || bus.imem_addr !== RST_PC + 32'd4) begin
      n_fail++;
      $display("FAIL rst_then_run: got addr=%h pc=%h v=%b want %h %h 1",
               bus.imem_addr, bus.pc_s1, bus.fetch_valid, RST_PC + 32'd4, RST_PC);
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      r = int'($urandom_range(0, 99));
      set_in((r < 70) ? 2'd0 : (r < 84) ? 2'd1 : (r < 97) ? 2'd2 : 2'd3,
             ($urandom_range(0, 3) == 0), $urandom, $urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #2 rst = 1'b0;
      end
      tick();
      n_checks++;
      if (bus.imem_addr !== m_addr || bus.pc_s1 !== m_pc || bus.fetch_valid !== m_good ||
          bus.kill_s1 !== !m_good || bus.redirect_cnt !== cnt_exp()) begin
        n_fail++;
        $display("FAIL random[%0d]: got addr=%h pc=%h v=%b k=%b cnt=%h want %h %h %b %b %h",
                 c, bus.imem_addr, bus.pc_s1, bus.fetch_valid, bus.kill_s1, bus.redirect_cnt,
                 m_addr, m_pc, m_good, !m_good, cnt_exp());
      end
      if (bus.fetch_valid === 1'b1 && bus.kill_s1 === 1'b1) begin
        n_fail++;
        $display("FAIL valid_and_kill[%0d]: got both 1 want at most one", c);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    set_in(2'd0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_boot();
    test_redirect();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_reboot();
    test_reset_mid_redirect();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
